mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared data-memory arbiter between the CPU MEM stage and a DMA engine.
// CPU has priority; a DMA request starved for STARVE_LIMIT cycles gets one forced grant.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_mem_read,
    input  logic        i_cpu_mem_write,
    input  logic [31:0] i_cpu_address,
    input  logic [31:0] i_cpu_write_data,
    output logic [31:0] o_cpu_read_data,
    output logic        o_cpu_stall,
    input  logic        i_dma_valid,
    input  logic        i_dma_write,
    input  logic [31:0] i_dma_address,
    input  logic [31:0] i_dma_write_data,
    output logic        o_dma_ready,
    output logic        o_dma_rvalid,
    output logic [31:0] o_dma_read_data,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    input  logic [31:0] i_mem_read_data
);

    typedef enum logic {S_NORMAL, S_FORCE} state_t;

    localparam logic [3:0] WAIT_MAX   = 4'hF;
    localparam logic [3:0] WAIT_FORCE = 4'(STARVE_LIMIT - 1);

    state_t     state;
    state_t     next_state;
    state_t     eff_state;
    logic [3:0] wait_count;
    logic       cpu_req;
    logic       cpu_grant;
    logic       dma_grant;

    assign cpu_req = i_cpu_mem_read | i_cpu_mem_write;

    // While reset is held the grant logic already behaves as in the reset state.
    assign eff_state = reset ? S_NORMAL : state;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_NORMAL;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_NORMAL;
        if (eff_state == S_NORMAL && i_dma_valid && !dma_grant && wait_count >= WAIT_FORCE)
            next_state = S_FORCE;
    end

    always_comb begin
        cpu_grant   = 1'b0;
        dma_grant   = 1'b0;
        o_cpu_stall = 1'b0;
        if (eff_state == S_FORCE) begin
            dma_grant   = i_dma_valid;
            cpu_grant   = cpu_req & ~i_dma_valid;
            o_cpu_stall = cpu_req & i_dma_valid;
        end else begin
            cpu_grant = cpu_req;
            dma_grant = i_dma_valid & ~cpu_req;
        end
    end

    assign o_dma_ready = dma_grant;

    // Single memory port: a store wins over a simultaneous load strobe from the CPU.
    always_comb begin
        o_mem_read       = 1'b0;
        o_mem_write      = 1'b0;
        o_mem_address    = '0;
        o_mem_write_data = '0;
        o_cpu_read_data  = '0;
        if (dma_grant) begin
            o_mem_read       = ~i_dma_write;
            o_mem_write      = i_dma_write;
            o_mem_address    = i_dma_address;
            o_mem_write_data = i_dma_write_data;
        end else if (cpu_grant) begin
            o_mem_read       = i_cpu_mem_read & ~i_cpu_mem_write;
            o_mem_write      = i_cpu_mem_write;
            o_mem_address    = i_cpu_address;
            o_mem_write_data = i_cpu_write_data;
            o_cpu_read_data  = i_mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            wait_count <= '0;
        else if (!i_dma_valid || dma_grant)
            wait_count <= '0;
        else if (wait_count != WAIT_MAX)
            wait_count <= wait_count + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_dma_rvalid    <= 1'b0;
            o_dma_read_data <= '0;
        end else begin
            o_dma_rvalid <= dma_grant & ~i_dma_write;
            if (dma_grant && !i_dma_write)
                o_dma_read_data <= i_mem_read_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a random run,
// all compared against a starvation-streak model of the arbitration rules.
module tb_mem_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cpu_mem_read, i_cpu_mem_write;
    logic [31:0] i_cpu_address, i_cpu_write_data;
    logic [31:0] o_cpu_read_data;
    logic        o_cpu_stall;
    logic        i_dma_valid, i_dma_write;
    logic [31:0] i_dma_address, i_dma_write_data;
    logic        o_dma_ready, o_dma_rvalid;
    logic [31:0] o_dma_read_data;
    logic        o_mem_read, o_mem_write;
    logic [31:0] o_mem_address, o_mem_write_data;
    logic [31:0] i_mem_read_data;

    int checks = 0;
    int errors = 0;

    int          m_streak = 0;
    bit          m_known  = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = '0;
    logic        m_last_acc = 1'b0;

    logic        smp_ready, smp_stall, smp_rvalid, smp_mem_read, smp_mem_write;
    logic [31:0] smp_cpu_rdata, smp_dma_rdata, smp_mem_addr, smp_mem_wdata;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_cpu_mem_read   (i_cpu_mem_read),
        .i_cpu_mem_write  (i_cpu_mem_write),
        .i_cpu_address    (i_cpu_address),
        .i_cpu_write_data (i_cpu_write_data),
        .o_cpu_read_data  (o_cpu_read_data),
        .o_cpu_stall      (o_cpu_stall),
        .i_dma_valid      (i_dma_valid),
        .i_dma_write      (i_dma_write),
        .i_dma_address    (i_dma_address),
        .i_dma_write_data (i_dma_write_data),
        .o_dma_ready      (o_dma_ready),
        .o_dma_rvalid     (o_dma_rvalid),
        .o_dma_read_data  (o_dma_read_data),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .o_mem_address    (o_mem_address),
        .o_mem_write_data (o_mem_write_data),
        .i_mem_read_data  (i_mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: samples at the falling edge, then advances the model.
    task automatic checkOutput();
        logic        cpu_req, forced, acc, cpu_ok, stall;
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wdata, e_crd;
        #4;
        cpu_req = i_cpu_mem_read | i_cpu_mem_write;
        forced  = !reset && (m_streak >= LIMIT);
        if (forced) begin
            acc    = i_dma_valid;
            cpu_ok = cpu_req && !i_dma_valid;
            stall  = cpu_req && i_dma_valid;
        end else begin
            cpu_ok = cpu_req;
            acc    = i_dma_valid && !cpu_req;
            stall  = 1'b0;
        end
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_crd = '0;
        if (acc) begin
            e_rd = !i_dma_write; e_wr = i_dma_write;
            e_addr = i_dma_address; e_wdata = i_dma_write_data;
        end else if (cpu_ok) begin
            e_wr = i_cpu_mem_write; e_rd = i_cpu_mem_read && !i_cpu_mem_write;
            e_addr = i_cpu_address; e_wdata = i_cpu_write_data;
            e_crd = i_mem_read_data;
        end

        smp_ready = o_dma_ready;       smp_stall = o_cpu_stall;
        smp_rvalid = o_dma_rvalid;     smp_mem_read = o_mem_read;
        smp_mem_write = o_mem_write;   smp_cpu_rdata = o_cpu_read_data;
        smp_dma_rdata = o_dma_read_data;
        smp_mem_addr = o_mem_address;  smp_mem_wdata = o_mem_write_data;

        do_check("dma_ready", {31'd0, smp_ready}, {31'd0, acc});
        do_check("cpu_stall", {31'd0, smp_stall}, {31'd0, stall});
        do_check("mem_read", {31'd0, smp_mem_read}, {31'd0, e_rd});
        do_check("mem_write", {31'd0, smp_mem_write}, {31'd0, e_wr});
        do_check("mem_addr", smp_mem_addr, e_addr);
        do_check("mem_wdata", smp_mem_wdata, e_wdata);
        do_check("cpu_rdata", smp_cpu_rdata, e_crd);
        if (m_known) begin
            do_check("dma_rvalid", {31'd0, smp_rvalid}, {31'd0, m_rvalid});
            do_check("dma_rdata", smp_dma_rdata, m_rdata);
        end

        @(posedge clk);
        m_last_acc = acc;
        if (reset) begin
            m_streak = 0; m_rvalid = 0; m_rdata = '0; m_known = 1'b1;
        end else begin
            m_rvalid = acc && !i_dma_write;
            if (m_rvalid) m_rdata = i_mem_read_data;
            if (i_dma_valid && !acc)
                m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
            else
                m_streak = 0;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic cr, input logic cw,
                                 input logic [31:0] ca, input logic [31:0] cwd,
                                 input logic dv, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input logic [31:0] mrd);
        reset = rst;
        i_cpu_mem_read = cr;  i_cpu_mem_write = cw;
        i_cpu_address = ca;   i_cpu_write_data = cwd;
        i_dma_valid = dv;     i_dma_write = dw;
        i_dma_address = da;   i_dma_write_data = dwd;
        i_mem_read_data = mrd;
        checkOutput();
    endtask

    initial begin
        int first_acc;
        int acc_count;
        int stall_count;
        logic        r_dv, r_dw;
        logic [31:0] r_da, r_dwd;

        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_2222);
        do_check("reset_rvalid", {31'd0, smp_rvalid}, 32'd0);
        do_check("reset_rdata", smp_dma_rdata, 32'd0);

        $display("[TB] CPU load, no DMA");
        applyStimulus(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        do_check("cpu_lw_rdata", smp_cpu_rdata, 32'hDEADBEEF);
        do_check("cpu_lw_memread", {31'd0, smp_mem_read}, 32'd1);
        do_check("cpu_lw_stall", {31'd0, smp_stall}, 32'd0);

        $display("[TB] DMA load with CPU idle");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 32'h12345678);
        do_check("dma_lw_ready", {31'd0, smp_ready}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE0000);
        do_check("dma_lw_rvalid", {31'd0, smp_rvalid}, 32'd1);
        do_check("dma_lw_rdata", smp_dma_rdata, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE0001);
        do_check("dma_lw_rvalid_pulse", {31'd0, smp_rvalid}, 32'd0);
        do_check("dma_lw_rdata_hold", smp_dma_rdata, 32'h12345678);

        $display("[TB] Starvation with continuous CPU traffic");
        first_acc = -1; acc_count = 0; stall_count = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 1, 0, 32'h100 + i, 0, 1, 0, 32'h200, 0, $urandom);
            if (smp_ready) begin
                if (first_acc < 0) first_acc = i;
                acc_count++;
            end
            if (smp_stall) stall_count++;
        end
        do_check("starve_first_accept", first_acc, 8);
        do_check("starve_accepts", acc_count, 2);
        do_check("starve_stalls", stall_count, 2);

        $display("[TB] Simultaneous CPU and DMA stores");
        applyStimulus(0, 0, 1, 32'h40, 32'hAAAA_0000, 1, 1, 32'h80, 32'h5555_0000, 0);
        do_check("sw_both_ready", {31'd0, smp_ready}, 32'd0);
        do_check("sw_both_addr", smp_mem_addr, 32'h40);
        do_check("sw_both_data", smp_mem_wdata, 32'hAAAA_0000);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h5555_0000, 0);
        do_check("dma_sw_addr", smp_mem_addr, 32'h80);
        do_check("dma_sw_data", smp_mem_wdata, 32'h5555_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_check("dma_sw_no_rvalid", {31'd0, smp_rvalid}, 32'd0);

        $display("[TB] Reset mid-starvation");
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 0);
        applyStimulus(1, 1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 0);
        first_acc = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 0);
            if (i == 0) do_check("rst_mid_rvalid", {31'd0, smp_rvalid}, 32'd0);
            if (smp_ready && first_acc < 0) first_acc = i;
        end
        do_check("rst_mid_first_accept", first_acc, 8);

        $display("[TB] DMA withdraws before forced grant");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 0, 32'h500, 0, 1, 1, 32'h600, 32'h77, 0);
        applyStimulus(0, 0, 1, 32'h504, 32'h99, 0, 1, 32'h600, 32'h77, 0);
        do_check("withdraw_ready", {31'd0, smp_ready}, 32'd0);
        do_check("withdraw_stall", {31'd0, smp_stall}, 32'd0);
        do_check("withdraw_addr", smp_mem_addr, 32'h504);
        applyStimulus(0, 1, 0, 32'h508, 0, 1, 1, 32'h600, 32'h77, 0);
        do_check("withdraw_cnt_cleared", {31'd0, smp_ready}, 32'd0);

        $display("[TB] DMA load accepted during reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h700, 0, 32'hBBBB_CCCC);
        do_check("rst_dma_ready", {31'd0, smp_ready}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_check("rst_dma_no_rvalid", {31'd0, smp_rvalid}, 32'd0);

        $display("[TB] Random traffic");
        r_dv = 0; r_dw = 0; r_da = '0; r_dwd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!r_dv || m_last_acc) begin
                r_dv  = ($urandom_range(0, 3) != 0);
                r_dw  = $urandom_range(0, 1) == 1;
                r_da  = $urandom;
                r_dwd = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                r_dv = 0;
            end
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
                          $urandom, $urandom, r_dv, r_dw, r_da, r_dwd, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
